oversample_bit_timer: RTL and testbench

Parametrised oversampling timer for the UART receive path. It counts clock edges within each bit period and bit periods within a frame, using a runtime-programmable oversampling ratio and frame length. It decodes three mid-bit sample strobes, a bit-boundary pulse and a frame-boundary pulse. It sits between the receive FSM, which drives `enable` and `clear`, and the majority-vote data-sampling block.

---
 rtl/uart_rx_pkg.sv | 7 +
 rtl/mid_bit_decode.sv | 21 ++
 rtl/oversample_bit_timer.sv | 81 ++++++++
 tb/tb_oversample_bit_timer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and types for the UART receive path
package uart_rx_pkg;
  localparam int MIN_PRESCALE = 4;
  localparam int DEF_PRESCALE = 8;
  localparam int DEF_FRAME_BITS = 10;
  typedef enum logic [1:0] {FIRST, MID, LAST} sample_idx_t;
endpackage

// File: rtl/mid_bit_decode.sv
// mid_bit_decode: decodes the three mid-bit sample strobes and the bit-end edge
module mid_bit_decode
  import uart_rx_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] edge_cnt,
  input  logic [W-1:0] p,
  output logic         sample_stb,
  output sample_idx_t  sample_idx,
  output logic         bit_done
);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] THREE = W'(3);
  logic [W-1:0] d;
  // Offset from the first sample edge; wraps high when before it, so one compare covers the window
  assign d = edge_cnt - ((p >> 1) - ONE);
  assign sample_stb = d < THREE;
  assign sample_idx = sample_stb ? sample_idx_t'(d[1:0]) : FIRST;
  assign bit_done = edge_cnt == p - ONE;
endmodule

// File: rtl/oversample_bit_timer.sv
// oversample_bit_timer: bit/frame timer with shadowed, normalised oversampling ratio.
// Optional OVERSAMPLE_BIT_TIMER_ERR_EN adds a registered cfg_err that freezes counting.
module oversample_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  bit_done,
`ifdef OVERSAMPLE_BIT_TIMER_ERR_EN
  output logic                  frame_done,
  output logic                  cfg_err
`else
  output logic                  frame_done
`endif
);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [PRESCALE_W-1:0] P_DEF = PRESCALE_W'(DEF_PRESCALE);
  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0] F_DEF = BIT_CNT_W'(DEF_FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] B_ONE = BIT_CNT_W'(1);
  logic [PRESCALE_W-1:0] p_sh, p_even, p_norm;
  logic [BIT_CNT_W-1:0] f_sh;
  logic load, hold, run, last_bit, d_stb, d_bd;
  sample_idx_t d_idx;
  assign load = !enable || clear;
  assign p_even = {prescale[PRESCALE_W-1:1], 1'b0};
  assign p_norm = p_even < P_MIN ? P_MIN : p_even;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p_sh <= P_DEF;
      f_sh <= F_DEF;
    end else if (load) begin
      p_sh <= p_norm;
      f_sh <= frame_bits;
    end
`ifdef OVERSAMPLE_BIT_TIMER_ERR_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) cfg_err <= 1'b0;
    else if (load) cfg_err <= prescale[0] || prescale < P_MIN || frame_bits == '0;
  assign hold = cfg_err;
`else
  assign hold = 1'b0;
`endif
  assign run = enable && !clear && !hold;
  // F=0 makes f_sh-1 all ones, so the wrap compare degenerates to modulo 2^BIT_CNT_W
  assign last_bit = bit_cnt == f_sh - B_ONE;
  mid_bit_decode #(.W(PRESCALE_W)) u_dec (
    .edge_cnt  (edge_cnt),
    .p         (p_sh),
    .sample_stb(d_stb),
    .sample_idx(d_idx),
    .bit_done  (d_bd)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (d_bd) begin
      edge_cnt <= '0;
      bit_cnt <= last_bit ? '0 : bit_cnt + B_ONE;
    end else
      edge_cnt <= edge_cnt + P_ONE;
  assign sample_stb = run && d_stb;
  assign sample_idx = run ? d_idx : 2'd0;
  assign bit_done = run && d_bd;
  assign frame_done = bit_done && last_bit && f_sh != '0;
endmodule

// File: tb/tb_oversample_bit_timer.sv
// tb_oversample_bit_timer: directed, table-driven checks of the oversampling bit timer
module tb_oversample_bit_timer;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] frame_bits = 4'd10;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic sample_stb, bit_done, frame_done, err_bit;
  logic [1:0] sample_idx;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  oversample_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .prescale(prescale), .frame_bits(frame_bits),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_stb(sample_stb), .sample_idx(sample_idx),
`ifdef OVERSAMPLE_BIT_TIMER_ERR_EN
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(err_bit)
`else
    .bit_done(bit_done), .frame_done(frame_done)
`endif
  );
`ifndef OVERSAMPLE_BIT_TIMER_ERR_EN
  assign err_bit = 1'b0;
`endif

  typedef struct {
    int pre;
    int fb;
    int p;
    int f;
    int n;
  } run_t;
  run_t runs[6];

  function automatic logic [15:0] act();
    return {edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, err_bit};
  endfunction

  // Expected outputs on the k-th enabled cycle (k=1 shows edge_cnt=0)
  function automatic logic [15:0] model(int p, int f, int k, bit err);
    int e, b, h, idx;
    bit stb, bd, fd;
    if (err) return 16'h0001;
    e = (k - 1) % p;
    b = ((k - 1) / p) % (f == 0 ? 16 : f);
    h = p / 2;
    stb = e >= h - 1 && e <= h + 1;
    idx = stb ? e - (h - 1) : 0;
    bd = e == p - 1;
    fd = bd && f != 0 && b == f - 1;
    return {6'(e), 4'(b), stb, 2'(idx), bd, fd, 1'b0};
  endfunction

  function automatic bit err_of(int pre, int fb);
`ifdef OVERSAMPLE_BIT_TIMER_ERR_EN
    return pre % 2 == 1 || pre < 4 || fb == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int k, input logic [15:0] exp);
    #1;
    checks++;
    if (act() !== exp) begin
      failures++;
      $display("FAIL %s k=%0d: got %h expected %h", name, k, act(), exp);
    end
    @(negedge clk);
  endtask

  task automatic span(input string name, input int p, input int f, input int k0, input int k1, input bit err);
    for (int k = k0; k <= k1; k++) chk(name, k, model(p, f, k, err));
  endtask

  task automatic start(input int pre, input int fb);
    enable = 1'b0;
    clear = 1'b0;
    prescale = 6'(pre);
    frame_bits = 4'(fb);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    runs[0] = '{8, 10, 8, 10, 81};
    runs[1] = '{16, 11, 16, 11, 177};
    runs[2] = '{9, 3, 8, 3, 26};
    runs[3] = '{3, 2, 4, 2, 9};
    runs[4] = '{4, 0, 4, 0, 70};
    runs[5] = '{0, 5, 4, 5, 21};
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act() !== 16'h0) begin
      failures++;
      $display("FAIL reset: got %h expected %h", act(), 16'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    foreach (runs[i]) begin
      start(runs[i].pre, runs[i].fb);
      span($sformatf("run%0d", i), runs[i].p, runs[i].f, 1, runs[i].n, err_of(runs[i].pre, runs[i].fb));
    end
    // Mid-frame prescale change is ignored until enable drops for a cycle
    start(8, 10);
    span("mid_old", 8, 10, 1, 3, 0);
    prescale = 6'd16;
    span("mid_old", 8, 10, 4, 20, 0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    span("mid_new", 16, 10, 1, 34, 0);
    // Clear with enable high at edge 5, bit 3
    start(8, 10);
    span("pre_clr", 8, 10, 1, 29, 0);
    clear = 1'b1;
    chk("clr_gate", 30, {6'd5, 4'd3, 6'b0});
    clear = 1'b0;
    span("post_clr", 8, 10, 1, 10, 0);
    // Asynchronous reset mid-frame restores 8/10 shadows
    start(16, 11);
    span("pre_rst", 16, 11, 1, 97, 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (act() !== 16'h0) begin
      failures++;
      $display("FAIL async_rst: got %h expected %h", act(), 16'h0);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    span("post_rst", 8, 10, 2, 82, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
